mandelbrot_multi: RTL and testbench

Multi-lane successor to the single-engine Mandelbrot state machine. Scans a full WIDTH x HEIGHT frame after one start pulse, dispatching pixels to NLANES parallel iteration lanes. Each lane owns one combinational mandelbrot_alu instance. Results leave through a valid/ready stream tagged with pixel coordinates, which feeds the display/framebuffer writer.

---
 rtl/mandelbrot_multi.sv | 250 +++++++++++++++++++++++++
 tb/tb_mandelbrot_multi.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mandelbrot_multi.sv
// Multi-lane Mandelbrot frame engine.
// A raster scanner hands pixels to NLANES iteration lanes, and each lane owns a
// combinational ALU. Finished counts leave through a valid/ready stream that is
// tagged with the pixel coordinates.

// One combinational iteration step: z' = z^2 + c.
// Fixed-point format: sign, 2 integer bits, WIDTH-3 fraction bits.
// size flags |z|^2 >= 4 for the incoming z. overflow flags a z' that cannot be
// represented in WIDTH bits.
module mandelbrot_alu #(
  parameter int WIDTH = 10
) (
  input  logic signed [WIDTH-1:0] zr,
  input  logic signed [WIDTH-1:0] zi,
  input  logic signed [WIDTH-1:0] cr,
  input  logic signed [WIDTH-1:0] ci,
  output logic signed [WIDTH-1:0] zr_out,
  output logic signed [WIDTH-1:0] zi_out,
  output logic                    size,
  output logic                    overflow
);
  localparam int FRAC = WIDTH - 3;
  localparam int PW   = 2 * WIDTH + 2;
  localparam logic signed [PW-1:0] FOUR = PW'(4) <<< FRAC;

  logic signed [PW-1:0] zr2, zi2, zri2, nr, ni;

  // Squares, cross term (2*zr*zi), escape test and range check
  always_comb begin
    zr2      = (PW'(zr) * PW'(zr)) >>> FRAC;
    zi2      = (PW'(zi) * PW'(zi)) >>> FRAC;
    zri2     = (PW'(zr) * PW'(zi)) >>> (FRAC - 1);
    nr       = zr2 - zi2 + PW'(cr);
    ni       = zri2 + PW'(ci);
    size     = (zr2 + zi2) >= FOUR;
    overflow = !(&nr[PW-1:WIDTH-1] || ~|nr[PW-1:WIDTH-1]) ||
               !(&ni[PW-1:WIDTH-1] || ~|ni[PW-1:WIDTH-1]);
    zr_out   = nr[WIDTH-1:0];
    zi_out   = ni[WIDTH-1:0];
  end
endmodule

module mandelbrot_multi #(
  parameter int BITWIDTH   = 10,
  parameter int CTRWIDTH   = 7,
  parameter int OUTWIDTH   = 4,
  parameter int SCALEWIDTH = 2,
  parameter int NLANES     = 2,
  parameter int HEIGHT     = 240,
  parameter int WIDTH      = 320,
  localparam int XW  = $clog2(WIDTH),
  localparam int YW  = $clog2(HEIGHT),
  localparam int SHW = $clog2(CTRWIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [CTRWIDTH-1:0]   max_ctr,
  input  logic [SHW-1:0]        ctr_shift,
  input  logic [SCALEWIDTH-1:0] scaling,
  input  logic [BITWIDTH-1:0]   cr_offset,
  input  logic [BITWIDTH-1:0]   ci_offset,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XW-1:0]         out_x,
  output logic [YW-1:0]         out_y,
  output logic [OUTWIDTH-1:0]   out_ctr
);
  localparam int LW = (NLANES > 1) ? $clog2(NLANES) : 1;

  typedef enum logic [1:0] {L_IDLE, L_ITER, L_DONE} lane_state_t;

  logic                  busy_reg, frame_done_reg, all_disp_reg;
  logic [XW-1:0]         x_reg;
  logic [YW-1:0]         y_reg;
  logic [CTRWIDTH-1:0]   max_ctr_reg;
  logic [SHW-1:0]        ctr_shift_reg;
  logic [SCALEWIDTH:0]   step_reg;
  logic [BITWIDTH-1:0]   cr_off_reg, ci_off_reg;

  logic [NLANES-1:0]     idle_vec, done_vec, load_vec, accept_vec;
  logic [LW-1:0]         sel_lane, grant_lane, lock_lane_reg;
  logic                  any_idle, dispatching, found_done, lock_reg, accept;
  logic [BITWIDTH-1:0]   disp_cr, disp_ci;

  logic [XW-1:0]         lane_x   [NLANES];
  logic [YW-1:0]         lane_y   [NLANES];
  logic [CTRWIDTH-1:0]   lane_ctr [NLANES];

  // Lowest idle lane receives the next pixel; c is offset + index*step, wrapping
  always_comb begin
    sel_lane = '0;
    any_idle = 1'b0;
    for (int i = 0; i < NLANES; i++) begin
      if (!any_idle && idle_vec[i]) begin
        sel_lane = LW'(i);
        any_idle = 1'b1;
      end
    end
    dispatching = busy_reg && !all_disp_reg && any_idle;
    disp_cr = cr_off_reg + BITWIDTH'(x_reg) * BITWIDTH'(step_reg);
    disp_ci = ci_off_reg + BITWIDTH'(y_reg) * BITWIDTH'(step_reg);
  end

  // Output grant: lowest done lane, unless a stalled grant is being held
  always_comb begin
    grant_lane = '0;
    found_done = 1'b0;
    for (int i = 0; i < NLANES; i++) begin
      if (!found_done && done_vec[i]) begin
        grant_lane = LW'(i);
        found_done = 1'b1;
      end
    end
    if (lock_reg) grant_lane = lock_lane_reg;
    out_valid = |done_vec;
    accept    = out_valid && out_ready;
    out_x     = lane_x[grant_lane];
    out_y     = lane_y[grant_lane];
    out_ctr   = OUTWIDTH'(lane_ctr[grant_lane] >> ctr_shift_reg);
  end

  // Grant lock keeps the payload stable across backpressure
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_reg      <= 1'b0;
      lock_lane_reg <= '0;
    end else if (out_valid && !out_ready) begin
      lock_reg      <= 1'b1;
      lock_lane_reg <= grant_lane;
    end else begin
      lock_reg      <= 1'b0;
    end
  end

  // Frame control: config latch, raster scan counters, completion
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
      all_disp_reg   <= 1'b0;
      x_reg          <= '0;
      y_reg          <= '0;
      max_ctr_reg    <= '0;
      ctr_shift_reg  <= '0;
      step_reg       <= '0;
      cr_off_reg     <= '0;
      ci_off_reg     <= '0;
    end else begin
      frame_done_reg <= 1'b0;
      if (start && !busy_reg) begin
        busy_reg      <= 1'b1;
        all_disp_reg  <= 1'b0;
        x_reg         <= '0;
        y_reg         <= '0;
        max_ctr_reg   <= max_ctr;
        ctr_shift_reg <= ctr_shift;
        step_reg      <= {1'b0, scaling} + 1'b1;
        cr_off_reg    <= cr_offset;
        ci_off_reg    <= ci_offset;
      end else if (busy_reg) begin
        if (dispatching) begin
          if (x_reg == XW'(WIDTH - 1)) begin
            x_reg <= '0;
            if (y_reg == YW'(HEIGHT - 1)) all_disp_reg <= 1'b1;
            else                          y_reg <= y_reg + 1'b1;
          end else begin
            x_reg <= x_reg + 1'b1;
          end
        end
        if (all_disp_reg && &idle_vec) begin
          busy_reg       <= 1'b0;
          frame_done_reg <= 1'b1;
        end
      end
    end
  end

  assign busy       = busy_reg;
  assign frame_done = frame_done_reg;

  for (genvar gi = 0; gi < NLANES; gi++) begin : g_lane
    lane_state_t                state_reg, state_next;
    logic signed [BITWIDTH-1:0] zr_reg, zi_reg, cr_reg, ci_reg;
    logic signed [BITWIDTH-1:0] alu_zr, alu_zi;
    logic                       alu_size, alu_ovf, ovf_reg, term;
    logic [CTRWIDTH-1:0]        ctr_reg;
    logic [XW-1:0]              x_tag_reg;
    logic [YW-1:0]              y_tag_reg;

    mandelbrot_alu #(.WIDTH(BITWIDTH)) u_alu (
      .zr(zr_reg), .zi(zi_reg), .cr(cr_reg), .ci(ci_reg),
      .zr_out(alu_zr), .zi_out(alu_zi), .size(alu_size), .overflow(alu_ovf)
    );

    assign term           = alu_size || ovf_reg || (ctr_reg == max_ctr_reg);
    assign idle_vec[gi]   = (state_reg == L_IDLE);
    assign done_vec[gi]   = (state_reg == L_DONE);
    assign load_vec[gi]   = dispatching && (sel_lane == LW'(gi));
    assign accept_vec[gi] = accept && (grant_lane == LW'(gi));
    assign lane_x[gi]     = x_tag_reg;
    assign lane_y[gi]     = y_tag_reg;
    assign lane_ctr[gi]   = ctr_reg;

    // Lane next-state: idle -> iterate -> hold result until accepted
    always_comb begin
      state_next = state_reg;
      case (state_reg)
        L_IDLE:  if (load_vec[gi])   state_next = L_ITER;
        L_ITER:  if (term)           state_next = L_DONE;
        L_DONE:  if (accept_vec[gi]) state_next = L_IDLE;
        default: state_next = L_IDLE;
      endcase
    end

    // Lane datapath: load on dispatch, one ALU step per iterating cycle
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state_reg <= L_IDLE;
        zr_reg    <= '0;
        zi_reg    <= '0;
        cr_reg    <= '0;
        ci_reg    <= '0;
        ctr_reg   <= '0;
        ovf_reg   <= 1'b0;
        x_tag_reg <= '0;
        y_tag_reg <= '0;
      end else begin
        state_reg <= state_next;
        if (state_reg == L_IDLE && load_vec[gi]) begin
          zr_reg    <= '0;
          zi_reg    <= '0;
          cr_reg    <= disp_cr;
          ci_reg    <= disp_ci;
          ctr_reg   <= '0;
          ovf_reg   <= 1'b0;
          x_tag_reg <= x_reg;
          y_tag_reg <= y_reg;
        end else if (state_reg == L_ITER && !term) begin
          zr_reg  <= alu_zr;
          zi_reg  <= alu_zi;
          ctr_reg <= ctr_reg + 1'b1;
          ovf_reg <= alu_ovf;
        end
      end
    end
  end
endmodule

// File: tb/tb_mandelbrot_multi.sv
// Self-checking bench: a 4-lane and a 1-lane engine run the same frames.
// Expected counts come from a plain-arithmetic escape-time model. The 4-lane
// results are checked by tag (out of order allowed), the 1-lane results are
// checked in strict raster order.
module tb_mandelbrot_multi;
  localparam int BW = 10, CW = 7, OW = 4, SW = 2, W = 8, H = 4;
  localparam int XW = $clog2(W), YW = $clog2(H), SHW = $clog2(CW);
  localparam int FRAC = BW - 3;
  localparam int NPIX = W * H;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [CW-1:0] max_ctr = '0;
  logic [SHW-1:0] ctr_shift = '0;
  logic [SW-1:0] scaling = '0;
  logic [BW-1:0] cr_offset = '0, ci_offset = '0;
  logic busy_a, fd_a, ov_a, rdy_a = 1'b1;
  logic busy_b, fd_b, ov_b, rdy_b = 1'b1;
  logic [XW-1:0] ox_a, ox_b;
  logic [YW-1:0] oy_a, oy_b;
  logic [OW-1:0] oc_a, oc_b;

  typedef struct { int x; int y; int c; } res_t;

  int total = 0, bad = 0;
  int got_a, got_b, fd_cnt_a, fd_cnt_b;
  int exp_tab [NPIX];
  bit pend_a [NPIX];
  res_t q_b [$];
  int rdy_mode = 0;
  bit stall_a = 0, stall_b = 0;
  logic [XW-1:0] px_a, px_b;
  logic [YW-1:0] py_a, py_b;
  logic [OW-1:0] pc_a, pc_b;

  always #5 clk = ~clk;

  mandelbrot_multi #(.BITWIDTH(BW), .CTRWIDTH(CW), .OUTWIDTH(OW), .SCALEWIDTH(SW),
                     .NLANES(4), .HEIGHT(H), .WIDTH(W)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .max_ctr(max_ctr), .ctr_shift(ctr_shift),
    .scaling(scaling), .cr_offset(cr_offset), .ci_offset(ci_offset), .busy(busy_a),
    .frame_done(fd_a), .out_valid(ov_a), .out_ready(rdy_a), .out_x(ox_a), .out_y(oy_a),
    .out_ctr(oc_a));

  mandelbrot_multi #(.BITWIDTH(BW), .CTRWIDTH(CW), .OUTWIDTH(OW), .SCALEWIDTH(SW),
                     .NLANES(1), .HEIGHT(H), .WIDTH(W)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .max_ctr(max_ctr), .ctr_shift(ctr_shift),
    .scaling(scaling), .cr_offset(cr_offset), .ci_offset(ci_offset), .busy(busy_b),
    .frame_done(fd_b), .out_valid(ov_b), .out_ready(rdy_b), .out_x(ox_b), .out_y(oy_b),
    .out_ctr(oc_b));

  task automatic check(input string name, input longint got, input longint want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", name, got, want);
    end
  endtask

  // Two's-complement wrap to BW bits
  function automatic longint wrapv(input longint v);
    longint m;
    m = v & ((longint'(1) << BW) - 1);
    if (m >= (longint'(1) << (BW - 1))) m -= (longint'(1) << BW);
    return m;
  endfunction

  // Escape-time count of z <- z^2 + c in s2.(BW-3) fixed point
  function automatic int mcount(input longint cr, input longint ci, input int mx);
    longint zr = 0, zi = 0, r2, i2, nr, ni;
    int ctr = 0;
    bit ovf = 0;
    for (int k = 0; k < 1000; k++) begin
      r2 = (zr * zr) >>> FRAC;
      i2 = (zi * zi) >>> FRAC;
      if ((r2 + i2) >= (longint'(4) << FRAC) || ovf || ctr == mx) return ctr;
      nr = r2 - i2 + cr;
      ni = ((zr * zi) >>> (FRAC - 1)) + ci;
      ovf = (nr != wrapv(nr)) || (ni != wrapv(ni));
      zr = wrapv(nr);
      zi = wrapv(ni);
      ctr++;
    end
    return ctr;
  endfunction

  // Ready drivers
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: begin rdy_a = 1'b1; rdy_b = 1'b1; end
        1: begin rdy_a = ($urandom_range(0, 3) != 0); rdy_b = ($urandom_range(0, 3) != 0); end
        default: begin rdy_a = 1'b0; rdy_b = 1'b0; end
      endcase
    end
  end

  // Monitor: stability under backpressure, scoreboard pops, frame_done
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_a = 0;
      stall_b = 0;
    end else begin
      if (stall_a) begin
        check("a_hold_valid", ov_a, 1);
        check("a_hold_payload", {ox_a, oy_a, oc_a}, {px_a, py_a, pc_a});
      end
      if (stall_b) begin
        check("b_hold_valid", ov_b, 1);
        check("b_hold_payload", {ox_b, oy_b, oc_b}, {px_b, py_b, pc_b});
      end
      if (ov_a && rdy_a) begin
        int idx;
        idx = int'(oy_a) * W + int'(ox_a);
        if (int'(ox_a) >= W || int'(oy_a) >= H || !pend_a[idx]) begin
          check("a_tag_unexpected", idx, -1);
        end else begin
          $display("a result x=%0d y=%0d ctr=%0d exp=%0d", ox_a, oy_a, oc_a, exp_tab[idx]);
          check("a_ctr", oc_a, exp_tab[idx]);
          pend_a[idx] = 0;
          got_a++;
        end
      end
      if (ov_b && rdy_b) begin
        res_t r;
        if (q_b.size() == 0) begin
          check("b_extra_result", {ox_b, oy_b}, -1);
        end else begin
          r = q_b.pop_front();
          $display("b result x=%0d y=%0d ctr=%0d exp=(%0d,%0d,%0d)", ox_b, oy_b, oc_b, r.x, r.y, r.c);
          check("b_raster_result", {ox_b, oy_b, oc_b}, {XW'(r.x), YW'(r.y), OW'(r.c)});
          got_b++;
        end
      end
      stall_a = ov_a && !rdy_a;
      px_a = ox_a; py_a = oy_a; pc_a = oc_a;
      stall_b = ov_b && !rdy_b;
      px_b = ox_b; py_b = oy_b; pc_b = oc_b;
      if (fd_a) begin fd_cnt_a++; check("a_busy_at_done", busy_a, 0); end
      if (fd_b) begin fd_cnt_b++; check("b_busy_at_done", busy_b, 0); end
    end
  end

  task automatic run_frame(input int cro, input int cio, input int sc, input int sh,
                           input int mx, input int stall_at, input int restart_at,
                           input int reset_at);
    int cyc;
    bit fin;
    got_a = 0; got_b = 0; fd_cnt_a = 0; fd_cnt_b = 0;
    q_b.delete();
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        int c;
        res_t r;
        c = mcount(wrapv(wrapv(cro) + x * (sc + 1)), wrapv(wrapv(cio) + y * (sc + 1)), mx);
        exp_tab[y * W + x] = (c >> sh) & ((1 << OW) - 1);
        pend_a[y * W + x] = 1;
        r.x = x; r.y = y; r.c = exp_tab[y * W + x];
        q_b.push_back(r);
      end
    end
    @(posedge clk); #1;
    cr_offset = BW'(cro); ci_offset = BW'(cio); scaling = SW'(sc);
    ctr_shift = SHW'(sh); max_ctr = CW'(mx); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // scramble config inputs; the latched copy must be used
    cr_offset = BW'($urandom); ci_offset = BW'($urandom);
    scaling = SW'($urandom); ctr_shift = SHW'($urandom);
    fin = 0;
    for (cyc = 0; cyc < 20000; cyc++) begin
      @(negedge clk);
      if (cyc == restart_at) begin
        start = 1'b1; max_ctr = CW'(mx + 3);
        @(negedge clk);
        start = 1'b0;
      end
      if (cyc == stall_at) begin
        int old_mode;
        old_mode = rdy_mode;
        rdy_mode = 2;
        repeat (50) @(negedge clk);
        check("a_valid_after_stall", ov_a, 1);
        check("b_valid_after_stall", ov_b, 1);
        rdy_mode = old_mode;
      end
      if (cyc == reset_at) begin
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("a_busy_after_reset", busy_a, 0);
        check("a_valid_after_reset", ov_a, 0);
        check("b_busy_after_reset", busy_b, 0);
        check("b_valid_after_reset", ov_b, 0);
        return;
      end
      if (!busy_a && !busy_b) begin fin = 1; break; end
    end
    if (!fin) check("frame_timeout", cyc, -1);
    repeat (3) @(negedge clk);
    check("a_result_count", got_a, NPIX);
    check("b_result_count", got_b, NPIX);
    check("a_frame_done_pulses", fd_cnt_a, 1);
    check("b_frame_done_pulses", fd_cnt_b, 1);
    check("a_busy_end", busy_a, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("a_reset_busy", busy_a, 0);
    check("a_reset_valid", ov_a, 0);
    check("a_reset_done", fd_a, 0);
    check("b_reset_busy", busy_b, 0);
    check("b_reset_valid", ov_b, 0);
    rst_n = 1'b1;
    // max_ctr = 0: every pixel reports 0
    run_frame($urandom_range(0, 1023), $urandom_range(0, 1023), 1, 0, 0, -1, -1, -1);
    // c = 0 at (0,0): never escapes, count saturates at max_ctr
    run_frame(0, 0, 0, 0, 5, -1, -1, -1);
    run_frame(0, 0, 0, 1, 5, -1, -1, -1);
    rdy_mode = 1;
    // start while busy with a different max_ctr is ignored
    run_frame(10'h3c0, 10'h3e0, 0, 0, 9, -1, 5, -1);
    // 50-cycle backpressure mid-frame
    run_frame(10'h380, 10'h3c0, 2, 1, 20, 10, -1, -1);
    // reset mid-frame, then a clean frame from (0,0)
    run_frame(10'h3a0, 10'h3d0, 1, 0, 30, -1, -1, 12);
    run_frame(10'h3a0, 10'h3d0, 1, 0, 30, -1, -1, -1);
    for (int f = 0; f < 6; f++) begin
      rdy_mode = f % 2;
      run_frame($urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 40), -1, -1, -1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
